// File: rtl/pent_mem_pager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pent_mem_pager                                             |
// | Description : Pentagon-style Z80 memory paging latch. Decodes writes to  |
// |               ports 7FFD and EFF7, synchronises the bus strobe into CLK, |
// |               and drives RAM page, ROM select and split CAS strobes.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pent_mem_pager #(
   parameter int PAGE_BITS = 3,   // RAM page width, 3..6 (128K..1024K)
   parameter int EXT_EN    = 1    // 1 = decode and honour port EFF7
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 IORQn,
   input  logic                 WRn,
   input  logic [15:0]          A,
   input  logic [7:0]           D,
   input  logic                 CAS,
   input  logic                 DIS,
   output logic [PAGE_BITS-1:0] RA,
   output logic                 ROM_SEL,
   output logic                 SCR_SEL,
   output logic                 CASn_RAM,
   output logic                 CASn_ROM,
   output logic                 LOCKED,
   output logic                 UPD
);

   // Fixed pages of the two middle banks
   localparam logic [PAGE_BITS-1:0] c_PAGE_BANK1 = PAGE_BITS'(5);
   localparam logic [PAGE_BITS-1:0] c_PAGE_BANK2 = PAGE_BITS'(2);

   // Strobe synchroniser: [0]=s1, [1]=s2, [2]=s3 (rise-detect history)
   logic [2:0] sync_q, sync_d;
   logic [7:0] p7_q, p7_d;
   logic [7:0] e7_q, e7_d;
   logic       upd_q, upd_d;

   logic                 w_wr_io;
   logic                 w_wstb;
   logic                 w_hit_7ffd;
   logic                 w_hit_eff7;
   logic                 w_acc_7ffd;
   logic                 w_acc_eff7;
   logic                 w_locked;
   logic                 w_rom_area;
   logic                 w_rom_cycle;
   logic [PAGE_BITS-1:0] w_page;
   logic                 w_unused_bits;

   assign w_wr_io = ~IORQn & ~WRn;
   assign w_wstb  = sync_q[1] & ~sync_q[2];

   // Partial address decode, as on the original board
   assign w_hit_7ffd = ~A[15] & ~A[1];
   assign w_hit_eff7 = (EXT_EN != 0) & (A[15:12] == 4'hE) & ~A[3];

   // Lock bit doubles as page bit 5 on 1024K boards; EFF7[2] defeats it
   assign w_locked   = p7_q[5] & ~e7_q[2];
   assign w_acc_7ffd = w_wstb & w_hit_7ffd & ~w_locked;
   assign w_acc_eff7 = w_wstb & w_hit_eff7;

   // Page field: low three bits direct, upper bits from D[7:5] reversed
   assign w_page[2:0] = p7_q[2:0];
   for (genvar i = 3; i < PAGE_BITS; i++) begin : g_page_hi
      assign w_page[i] = p7_q[10-i];
   end

   // EFF7 bits other than [3:2] are stored but have no function; A bits not in any decode
   assign w_unused_bits = ^{e7_q[7:4], e7_q[1:0], A[11:4], A[2], A[0]};

   // Next-state for the synchroniser, paging registers and update pulse
   always_comb begin
      sync_d = {sync_q[1:0], w_wr_io};
      p7_d   = w_acc_7ffd ? D : p7_q;
      e7_d   = w_acc_eff7 ? D : e7_q;
      upd_d  = w_acc_7ffd | w_acc_eff7;
   end

   // State registers; reset abandons any write in flight
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sync_q <= 3'b000;
         p7_q   <= 8'h00;
         e7_q   <= 8'h00;
         upd_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         p7_q   <= p7_d;
         e7_q   <= e7_d;
         upd_q  <= upd_d;
      end
   end

   // Bank-to-page mapping from the CPU's top address bits
   always_comb begin
      case (A[15:14])
         2'b11:   RA = w_page;
         2'b10:   RA = c_PAGE_BANK2;
         2'b01:   RA = c_PAGE_BANK1;
         default: RA = '0;
      endcase
   end

   // DIS in the ROM area steers the access to RAM (shadow ROM lives in RAM)
   assign w_rom_area  = (A[15:14] == 2'b00) & ~e7_q[3];
   assign w_rom_cycle = w_rom_area & ~DIS;
   assign CASn_ROM    = ~(CAS & w_rom_cycle);
   assign CASn_RAM    = ~(CAS & ~w_rom_cycle);

   assign ROM_SEL = p7_q[4];
   assign SCR_SEL = p7_q[3];
   assign LOCKED  = w_locked;
   assign UPD     = upd_q;

endmodule
`default_nettype wire

// File: doc/pent_mem_pager.md
# pent_mem_pager

Clocked, parametrised successor to the Pentagon paging latch. Decodes Z80 writes to port 7FFD and, optionally, the extended port EFF7, and holds the paging state. Drives the RAM page address, the ROM select and the split RAM/ROM CAS strobes for the DRAM controller. Over the original latch it adds:
- a configurable page width (128K up to 1024K)
- a lock override from EFF7
- RAM-at-0000 mapping
- bus-strobe synchronisation into the system clock domain
- a one-cycle update pulse

## Interface
Parameters:
- PAGE_BITS, 3, RAM page address width; legal 3..6 (128K..1024K); page bits above 2 come from D[7:5] as below
- EXT_EN, 1, 1 = decode port EFF7 and honour its bits; 0 = EFF7 ignored, its register held at 0

Ports:
- CLK  in  1  system clock; all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- IORQn  in  1  Z80 I/O request, asynchronous to CLK
- WRn  in  1  Z80 write strobe, asynchronous to CLK
- A  in  16  Z80 address bus
- D  in  8  Z80 data bus; stable while IORQn and WRn are low
- CAS  in  1  DRAM CAS timing from the controller, active high
- DIS  in  1  external ROM disable, active high (e.g. TR-DOS shadow)
- RA  out  PAGE_BITS  physical RAM page for the current A[15:14]
- ROM_SEL  out  1  high = ROM bank 1 (48K BASIC), low = bank 0
- SCR_SEL  out  1  screen select, 7FFD bit 3
- CASn_RAM  out  1  active-low CAS to RAM
- CASn_ROM  out  1  active-low CAS to ROM
- LOCKED  out  1  7FFD lock state
- UPD  out  1  one-CLK pulse on every accepted register write

## Operation
Bus strobe handling:
- wr_io = ~IORQn & ~WRn, synchronised through two flops (s1, s2).
- A third flop s3 gives rise detect: wstb = s2 & ~s3.
- A and D are sampled on the CLK edge where wstb = 1.

Port 7FFD:
- Decoded when A15=0 and A1=0.
- Accepted only when LOCKED=0; a locked write is dropped.
- Register P7 (8 bits) <= D.
- Bit fields: [2:0] page low, [3] SCR_SEL, [4] ROM_SEL, [5] lock.
- With PAGE_BITS>3, page bits [PAGE_BITS-1:3] = D[7:5] in order (bit3<=D7, bit4<=D6, bit5<=D5). Bit 5 is then both lock and page bit 5, Pentagon-1024 style: lock is only effective when EFF7[2]=0.

Port EFF7 (EXT_EN=1):
- Decoded when A[15:12]=1110 and A3=0; never locked.
- Register E7 (8 bits) <= D.
- E7[2]: lock disable, forcing LOCKED=0.
- E7[3]: RAM at 0000, so A15:14=00 maps to RAM page 0 instead of ROM.
- Other bits are stored and unused.

LOCKED = P7[5] & ~E7[2].

A decode that hits both ports updates both registers on the same edge, subject to each port's own rules.

UPD = 1 for the cycle following any accepted write, whether or not the register value changed. A dropped (locked) write gives UPD=0.

Page mapping (combinational from A[15:14]):
- 11 → page field of P7
- 10 → 2
- 01 → 5
- 00 → ROM area, RA = 0

rom_area = (A15:14==00) & ~E7[3].

CAS routing:
- CASn_ROM = ~(CAS & rom_area & ~DIS)
- CASn_RAM = ~(CAS & ~(rom_area & ~DIS))
- DIS in the ROM area therefore routes the access to RAM, as in the original logic.

Reset: P7 = 0, E7 = 0, s1..s3 = 0.
- UPD = 0, LOCKED = 0, ROM_SEL = 0, SCR_SEL = 0.
- RA follows A (page 0 for the top bank).
- CASn_RAM = CASn_ROM = 1 while CAS = 0.

## Timing
- Write latency: wr_io low→high transition sampled at edge k; register and UPD update at edge k+2. RA, ROM_SEL and SCR_SEL change at k+2.
- Strobe width: wr_io must stay asserted ≥3 CLK, with D and A stable over that window. One I/O cycle gives exactly one accepted write.
- Back-to-back I/O writes need wr_io deasserted ≥2 CLK between them.
- RA, CASn_* and rom_area are purely combinational from A, CAS and DIS, with no CLK latency.
- RSTn assertion mid-write clears all state immediately; the pending write is lost.
- On RSTn release the synchronisers start at 0, so a strobe already low is seen as a new write, which is accepted.

## Test plan
- Reset, then OUT 7FFD,0x17 → UPD pulse at k+2; with A15:14=11, RA=7; ROM_SEL=1; LOCKED=0.
- OUT 7FFD,0x20 then OUT 7FFD,0x07 → second write dropped, no UPD, RA stays 0, LOCKED=1.
- EXT_EN=1, locked, OUT EFF7,0x04 → LOCKED=0; following OUT 7FFD,0x03 gives RA=3.
- PAGE_BITS=6, OUT 7FFD,0xC2 → RA=0b011010 (26) for the top bank.
- OUT EFF7,0x08; A15:14=00, CAS=1 → CASn_RAM=0, CASn_ROM=1, RA=0. Repeat with E7=0 and DIS=0 → CASn_ROM=0; with DIS=1 → CASn_RAM=0.
- Hold strobe low across RSTn pulse → registers 0 during reset; single write accepted after release; A15:14=01 → RA=5, A15:14=10 → RA=2 throughout.
